// File: rtl/barrel_shifter_pipe.sv
// Log-depth barrel shifter with one register per mux layer and a global-stall
// ready/valid handshake. Modes: funnel-right, arith-right, logical-left, rotate-right.
module barrel_shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_fill,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    MODE_FUNNEL = 2'b00,
    MODE_ASR    = 2'b01,
    MODE_SHL    = 2'b10,
    MODE_ROR    = 2'b11
  } mode_e;

  // Right-shifting modes are all a funnel of {upper, data}; only the upper word differs.
  function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] f,
                                                  input logic [1:0]       mode,
                                                  input logic             en,
                                                  input int               s);
    logic [2*WIDTH-1:0] cat;
    cat = {f, d};
    case (mode)
      MODE_FUNNEL: cat = {f, d};
      MODE_ASR:    cat = {{WIDTH{d[WIDTH-1]}}, d};
      MODE_ROR:    cat = {d, d};
      default:     cat = {f, d};
    endcase
    if (!en) begin
      shift_data = d;
    end else if (mode == MODE_SHL) begin
      shift_data = d << s;
    end else begin
      shift_data = WIDTH'(cat >> s);
    end
  endfunction

  function automatic logic [WIDTH-1:0] shift_fill(input logic [WIDTH-1:0] f,
                                                  input logic             en,
                                                  input int               s);
    shift_fill = en ? (f >> s) : f;
  endfunction

  logic adv;

  for (genvar j = 0; j < SHW; j++) begin : g_layer
    localparam int S = 1 << j;

    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] f_in;
    logic [SHW-j-1:0] a_in;
    logic [1:0]       m_in;
    logic [TAG_W-1:0] t_in;
    logic             v_in;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [TAG_W-1:0] tag_q;
    logic             valid_q;

    if (j == 0) begin : g_src
      assign d_in = in_data;
      assign f_in = in_fill;
      assign a_in = in_amt;
      assign m_in = in_mode;
      assign t_in = in_tag;
      assign v_in = in_valid;
    end else begin : g_src
      assign d_in = g_layer[j-1].data_q;
      assign f_in = g_layer[j-1].g_carry.fill_q;
      assign a_in = g_layer[j-1].g_carry.amt_q;
      assign m_in = g_layer[j-1].g_carry.mode_q;
      assign t_in = g_layer[j-1].tag_q;
      assign v_in = g_layer[j-1].valid_q;
    end

    // a_in[0] is this layer's amount bit; consumed bits are dropped stage by stage.
    assign data_d = shift_data(d_in, f_in, m_in, a_in[0], S);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        tag_q   <= '0;
        valid_q <= 1'b0;
      end else if (adv) begin
        data_q  <= data_d;
        tag_q   <= t_in;
        valid_q <= v_in;
      end
    end

    if (j < SHW - 1) begin : g_carry
      logic [WIDTH-1:0] fill_q;
      logic [SHW-j-2:0] amt_q;
      logic [1:0]       mode_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fill_q <= '0;
          amt_q  <= '0;
          mode_q <= '0;
        end else if (adv) begin
          fill_q <= shift_fill(f_in, a_in[0], S);
          amt_q  <= a_in[SHW-j-1:1];
          mode_q <= m_in;
        end
      end
    end
  end

  assign out_valid = g_layer[SHW-1].valid_q;
  assign out_data  = g_layer[SHW-1].data_q;
  assign out_tag   = g_layer[SHW-1].tag_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: driver pushes expected results,
// an independent monitor pops and compares on every output transfer.
module tb_barrel_shifter_pipe;
  localparam int W   = 16;
  localparam int TW  = 4;
  localparam int SHW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  in_fill = '0;
  logic [SHW-1:0] in_amt = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  barrel_shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_fill(in_fill),
    .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low
  bit   lat_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] d,
                                         input logic [W-1:0] f, input logic [SHW-1:0] k);
    logic [2*W-1:0] c;
    case (m)
      2'b00: begin
        c = {f, d} >> k;
        return c[W-1:0];
      end
      2'b01: return W'($signed(d) >>> k);
      2'b10: return d << k;
      default: return (d >> k) | (d << (W - k));
    endcase
  endfunction

  // Monitor: samples 2 time units after the falling edge, when the handshake is settled.
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_data;
  logic [TW-1:0] prev_tag;

  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("data", out_data, e.data);
          check("tag", out_tag, e.tag);
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, SHW);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input bit v, input logic [1:0] m, input logic [W-1:0] d,
                      input logic [W-1:0] f, input logic [SHW-1:0] a, input logic [TW-1:0] t,
                      input logic [W-1:0] exp, output bit acc);
    @(negedge clk);
    case (rdy_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    in_valid = v;
    in_mode  = m;
    in_data  = d;
    in_fill  = f;
    in_amt   = a;
    in_tag   = t;
    #1;
    acc = v && in_ready;
    if (acc) sbq.push_back('{data: exp, tag: t, acc_cyc: cyc, chk_lat: lat_chk});
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] f,
                      input logic [SHW-1:0] a, input logic [TW-1:0] t, input logic [W-1:0] exp);
    bit acc;
    int n = 0;
    do begin
      step(1'b1, m, d, f, a, t, exp, acc);
      n++;
    end while (!acc && n < 1000);
    if (!acc) check("accept_timeout", in_ready, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, '0, '0, '0, acc);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (sbq.size() > 0 && n < max_cyc) begin
      idle(1);
      n++;
    end
    idle(2);
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   d, f;
    logic [SHW-1:0] a;
    logic [1:0]     m;
    bit             acc;
    int             scyc;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results and latency check.
    lat_chk = 1'b1;
    send(2'b00, 16'h8001, 16'hABCD, 4'd4, 4'h1, 16'hD800);
    drain(20);
    send(2'b01, 16'h8000, 16'h0000, 4'd15, 4'h2, 16'hFFFF);
    send(2'b01, 16'h8000, 16'h0000, 4'd3,  4'h3, 16'hF000);
    send(2'b01, 16'h4000, 16'h0000, 4'd14, 4'h4, 16'h0001);
    send(2'b10, 16'h0001, 16'h0000, 4'd15, 4'h5, 16'h8000);
    send(2'b11, 16'h0001, 16'h0000, 4'd1,  4'h6, 16'h8000);
    send(2'b00, 16'h1234, 16'hFFFF, 4'd0,  4'h7, 16'h1234);
    send(2'b01, 16'h9ABC, 16'h5555, 4'd0,  4'h8, 16'h9ABC);
    send(2'b10, 16'h5A5A, 16'hFFFF, 4'd0,  4'h9, 16'h5A5A);
    send(2'b11, 16'hC3C3, 16'h0000, 4'd0,  4'hA, 16'hC3C3);
    send(2'b00, 16'h0000, 16'h7FFF, 4'd15, 4'hB, 16'hFFFE);
    send(2'b11, 16'h8001, 16'h0000, 4'd15, 4'hC, 16'h0003);
    drain(20);

    // Back-to-back stream of 20 with out_ready low in stream cycles 5-7.
    lat_chk = 1'b0;
    scyc = 0;
    for (int i = 0; i < 20; i++) begin
      d = W'($urandom);
      f = W'($urandom);
      a = SHW'($urandom);
      m = 2'($urandom);
      do begin
        rdy_mode = (scyc >= 5 && scyc <= 7) ? 2 : 0;
        step(1'b1, m, d, f, a, TW'(i), model(m, d, f, a), acc);
        if (rdy_mode == 2) check("stall_in_ready", in_ready, 0);
        scyc++;
      end while (!acc && scyc < 200);
    end
    rdy_mode = 0;
    drain(40);

    // Reset with three operations in flight, output stalled.
    send(2'b10, 16'h0003, 16'h0000, 4'd1, 4'h1, 16'h0006);
    send(2'b10, 16'h0003, 16'h0000, 4'd2, 4'h2, 16'h000C);
    send(2'b10, 16'h0003, 16'h0000, 4'd3, 4'h3, 16'h0018);
    rdy_mode = 2;
    idle(2);
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_tag", out_tag, 0);
    sbq.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    rdy_mode = 0;
    idle(6);
    lat_chk = 1'b1;
    send(2'b10, 16'h00F0, 16'h0000, 4'd4, 4'hD, 16'h0F00);
    drain(20);
    idle(6);

    // Random operations with random backpressure.
    lat_chk  = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      d = W'($urandom);
      f = W'($urandom);
      a = SHW'($urandom);
      m = 2'($urandom);
      send(m, d, f, a, TW'(i), model(m, d, f, a));
    end
    drain(1000);
    rdy_mode = 0;
    idle(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
